// File: rtl/temperature_scan_scheduler.sv
// Round-robin scheduler sharing one temperature range checker across NUM_CH channels, with debounced per-channel alarms.
// Optional build macro TEMP_ALARM_LATCH_EN: alarms latch until alarm_ack instead of auto-clearing.
module temperature_scan_scheduler #(
  parameter int          CH_W    = 2,
  parameter logic [7:0]  LOW     = 8'd35,
  parameter logic [7:0]  HIGH    = 8'd39,
  parameter int          PERSIST = 3
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [2**CH_W-1:0]        req,
  input  logic [8*(2**CH_W)-1:0]    temp_bus,
  output logic [2**CH_W-1:0]        gnt,
  output logic                      result_valid,
  output logic [CH_W-1:0]           result_ch,
  output logic                      result_abn,
  output logic [2**CH_W-1:0]        alarm,
  input  logic [2**CH_W-1:0]        alarm_ack,
  output logic                      any_alarm
);

  localparam int         NUM_CH    = 2**CH_W;
  localparam logic [4:0] PERSIST_M = 5'(PERSIST);

  typedef enum logic [1:0] {IDLE, EVAL, UPDATE} state_t;

  state_t          state;
  logic [CH_W-1:0] ptr;
  logic [CH_W-1:0] idx;
  logic [7:0]      sample;
  logic [3:0]      cnt [NUM_CH];

  logic            gnt_any;
  logic [CH_W-1:0] gnt_idx;
  logic [CH_W-1:0] cand;

  logic            hit;
  logic            set_ev;
  logic [3:0]      upd_cnt;
  logic            upd_alarm;

  // Round-robin search starting just after the last granted channel; held off while in reset.
  always_comb begin
    gnt     = '0;
    gnt_any = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    if (state == IDLE && rst_n) begin
      for (int k = 1; k <= NUM_CH; k++) begin
        cand = ptr + CH_W'(k);
        if (!gnt_any && req[cand]) begin
          gnt_any = 1'b1;
          gnt_idx = cand;
        end
      end
    end
    if (gnt_any) gnt[gnt_idx] = 1'b1;
  end

  // Next counter/alarm for the channel being updated: count samples that disagree with the current alarm.
  always_comb begin
    upd_cnt   = cnt[idx];
    upd_alarm = alarm[idx];
    set_ev    = 1'b0;
    hit       = (({1'b0, cnt[idx]} + 5'd1) == PERSIST_M);
    if (result_abn != alarm[idx]) begin
      if (hit) begin
        upd_cnt = 4'd0;
        if (!alarm[idx]) begin
          set_ev    = 1'b1;
          upd_alarm = 1'b1;
        end else begin
`ifdef TEMP_ALARM_LATCH_EN
          upd_alarm = 1'b1;
`else
          upd_alarm = 1'b0;
`endif
        end
      end else begin
        upd_cnt = cnt[idx] + 4'd1;
      end
    end else begin
      upd_cnt = 4'd0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      ptr          <= CH_W'(NUM_CH - 1);
      idx          <= '0;
      sample       <= '0;
      result_valid <= 1'b0;
      result_ch    <= '0;
      result_abn   <= 1'b0;
      alarm        <= '0;
      for (int i = 0; i < NUM_CH; i++) cnt[i] <= 4'd0;
    end else begin
      result_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (gnt_any) begin
            idx    <= gnt_idx;
            ptr    <= gnt_idx;
            sample <= temp_bus[{gnt_idx, 3'b000} +: 8];
            state  <= EVAL;
          end
        end
        EVAL: begin
          result_abn   <= (sample > HIGH) || (sample < LOW);
          result_ch    <= idx;
          result_valid <= 1'b1;
          state        <= UPDATE;
        end
        UPDATE:  state <= IDLE;
        default: state <= IDLE;
      endcase

      for (int i = 0; i < NUM_CH; i++) begin
        if (state == UPDATE && idx == CH_W'(i)) begin
`ifdef TEMP_ALARM_LATCH_EN
          if (!set_ev && alarm_ack[i]) begin
            alarm[i] <= 1'b0;
            cnt[i]   <= 4'd0;
          end else begin
            alarm[i] <= upd_alarm;
            cnt[i]   <= upd_cnt;
          end
`else
          alarm[i] <= upd_alarm;
          cnt[i]   <= upd_cnt;
`endif
        end
`ifdef TEMP_ALARM_LATCH_EN
        else if (alarm_ack[i]) begin
          alarm[i] <= 1'b0;
          cnt[i]   <= 4'd0;
        end
`endif
      end
    end
  end

`ifndef TEMP_ALARM_LATCH_EN
  logic unused_ack;
  assign unused_ack = ^alarm_ack;
`endif

  assign any_alarm = |alarm;

endmodule

// File: tb/tb_temperature_scan_scheduler.sv
// Self-checking bench for temperature_scan_scheduler: directed test-plan steps plus randomized samples against a behavioural model.
module tb_temperature_scan_scheduler;

  localparam int         CH_W    = 2;
  localparam int         NUM_CH  = 4;
  localparam int         PERSIST = 3;
  localparam logic [7:0] LOW     = 8'd35;
  localparam logic [7:0] HIGH    = 8'd39;
`ifdef TEMP_ALARM_LATCH_EN
  localparam bit LATCH = 1'b1;
`else
  localparam bit LATCH = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req = '0;
  logic [31:0] temp_bus = '0;
  logic [3:0]  alarm_ack = '0;
  logic [3:0]  gnt;
  logic        result_valid;
  logic [1:0]  result_ch;
  logic        result_abn;
  logic [3:0]  alarm;
  logic        any_alarm;

  temperature_scan_scheduler #(.CH_W(CH_W), .LOW(LOW), .HIGH(HIGH), .PERSIST(PERSIST)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .temp_bus(temp_bus), .gnt(gnt),
    .result_valid(result_valid), .result_ch(result_ch), .result_abn(result_abn),
    .alarm(alarm), .alarm_ack(alarm_ack), .any_alarm(any_alarm)
  );

  always #5 clk = ~clk;

  int       compared = 0;
  int       mismatched = 0;
  bit [3:0] mAlarm;
  int       mRun [NUM_CH];
  int       mLast;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] mask, input logic [31:0] temps);
    req      = mask;
    temp_bus = temps;
  endtask

  function automatic bit isAbn(input logic [7:0] t);
    return (t > HIGH) || (t < LOW);
  endfunction

  function automatic int pickGrant(input logic [3:0] mask, input int last);
    for (int k = 1; k <= NUM_CH; k++)
      if (mask[(last + k) % NUM_CH]) return (last + k) % NUM_CH;
    return -1;
  endfunction

  task automatic modelReset();
    mAlarm = '0;
    mLast  = NUM_CH - 1;
    for (int i = 0; i < NUM_CH; i++) mRun[i] = 0;
  endtask

  // A run of PERSIST consecutive samples contrary to the alarm flips it (or only restarts the run once latched).
  task automatic modelUpdate(input int ch, input bit abn);
    if (abn != mAlarm[ch]) begin
      mRun[ch]++;
      if (mRun[ch] == PERSIST) begin
        mRun[ch] = 0;
        if (!mAlarm[ch]) mAlarm[ch] = 1'b1;
        else if (!LATCH) mAlarm[ch] = 1'b0;
      end
    end else begin
      mRun[ch] = 0;
    end
  endtask

  task automatic waitGrant(output int waited);
    waited = 0;
    #1;
    while (gnt == '0 && waited < 8) begin
      @(posedge clk); #2;
      waited++;
    end
    checkOutput("grant_seen", {31'd0, gnt != '0}, 32'd1);
  endtask

  task automatic finishTxn(input int ch, input logic [7:0] t, input bit keep);
    bit abn;
    abn = isAbn(t);
    @(posedge clk); #1;
    if (!keep) req = '0;
    #1;
    checkOutput("valid_eval", {31'd0, result_valid}, 32'd0);
    @(posedge clk); #2;
    checkOutput("valid_upd", {31'd0, result_valid}, 32'd1);
    checkOutput("result_ch", {30'd0, result_ch}, 32'(ch));
    checkOutput("result_abn", {31'd0, result_abn}, {31'd0, abn});
    checkOutput("alarm_pre", {28'd0, alarm}, {28'd0, mAlarm});
    modelUpdate(ch, abn);
    @(posedge clk); #2;
    checkOutput("valid_done", {31'd0, result_valid}, 32'd0);
    checkOutput("alarm_post", {28'd0, alarm}, {28'd0, mAlarm});
    checkOutput("any_alarm", {31'd0, any_alarm}, {31'd0, |mAlarm});
  endtask

  task automatic doSample(input int ch, input logic [7:0] t);
    logic [31:0] tb;
    int w;
    int e;
    tb = temp_bus;
    tb[ch*8 +: 8] = t;
    applyStimulus(4'(1 << ch), tb);
    waitGrant(w);
    e = pickGrant(4'(1 << ch), mLast);
    checkOutput("gnt_single", {28'd0, gnt}, 32'(1 << e));
    mLast = e;
    finishTxn(e, t, 1'b0);
  endtask

  task automatic pulseAck(input logic [3:0] mask);
    @(posedge clk); #1;
    alarm_ack = mask;
    @(posedge clk); #1;
    alarm_ack = '0;
    if (LATCH) begin
      for (int i = 0; i < NUM_CH; i++)
        if (mask[i]) begin mAlarm[i] = 1'b0; mRun[i] = 0; end
    end
    #1;
    checkOutput("alarm_ack", {28'd0, alarm}, {28'd0, mAlarm});
  endtask

  initial begin
    int w;
    int e;
    time t0;
    time t1;
    logic [31:0] temps;
    logic [3:0] mask;
    logic [7:0] ch1Seq [8];

    // Reset values
    modelReset();
    repeat (2) @(posedge clk);
    #2;
    checkOutput("rst_gnt", {28'd0, gnt}, 32'd0);
    checkOutput("rst_valid", {31'd0, result_valid}, 32'd0);
    checkOutput("rst_ch", {30'd0, result_ch}, 32'd0);
    checkOutput("rst_abn", {31'd0, result_abn}, 32'd0);
    checkOutput("rst_alarm", {28'd0, alarm}, 32'd0);
    checkOutput("rst_any", {31'd0, any_alarm}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #2;

    $display("[TB] single sample ch0");
    doSample(0, 8'd37);

    $display("[TB] fairness with all channels requesting");
    applyStimulus(4'b1111, {8'd37, 8'd37, 8'd37, 8'd37});
    t0 = 0;
    for (int n = 0; n < 5; n++) begin
      waitGrant(w);
      t1 = $time;
      e = pickGrant(4'b1111, mLast);
      checkOutput("rr_gnt", {28'd0, gnt}, 32'(1 << e));
      if (n > 0) checkOutput("rr_spacing", 32'(t1 - t0), 32'd30);
      t0 = t1;
      mLast = e;
      finishTxn(e, 8'd37, 1'b1);
    end
    req = '0;

    $display("[TB] persistence on ch2");
    repeat (3) doSample(2, 8'd41);
    checkOutput("ch2_set", {31'd0, alarm[2]}, 32'd1);
    pulseAck(4'b0000);
    repeat (3) doSample(2, 8'd37);
    pulseAck(4'b0100);
    checkOutput("ch2_cleared", {31'd0, alarm[2]}, 32'd0);

    $display("[TB] ch1 counter reset and band edges");
    ch1Seq = '{8'd41, 8'd41, 8'd37, 8'd41, 8'd35, 8'd39, 8'd34, 8'd40};
    for (int i = 0; i < 8; i++) doSample(1, ch1Seq[i]);
    doSample(1, 8'd37);

    $display("[TB] reset during EVAL");
    doSample(3, 8'd37);
    temps = temp_bus;
    temps[31:24] = 8'd45;
    applyStimulus(4'b1000, temps);
    waitGrant(w);
    checkOutput("mid_gnt", {28'd0, gnt}, 32'h8);
    @(posedge clk); #1;
    rst_n = 1'b0;
    modelReset();
    #1;
    checkOutput("mid_rst_valid", {31'd0, result_valid}, 32'd0);
    checkOutput("mid_rst_alarm", {28'd0, alarm}, 32'd0);
    applyStimulus(4'b1010, {8'd45, 8'd0, 8'd36, 8'd0});
    repeat (2) begin
      @(posedge clk); #2;
      checkOutput("hold_valid", {31'd0, result_valid}, 32'd0);
      checkOutput("hold_gnt", {28'd0, gnt}, 32'd0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    waitGrant(w);
    checkOutput("post_rst_wait", 32'(w), 32'd0);
    checkOutput("post_rst_gnt", {28'd0, gnt}, 32'h2);
    mLast = 1;
    finishTxn(1, 8'd36, 1'b0);
    repeat (2) doSample(3, 8'd45);
    checkOutput("ch3_no_alarm", {31'd0, alarm[3]}, 32'd0);

    $display("[TB] randomized traffic");
    for (int n = 0; n < 40; n++) begin
      mask = 4'($urandom_range(1, 15));
      for (int c = 0; c < NUM_CH; c++) temps[c*8 +: 8] = 8'($urandom_range(30, 45));
      applyStimulus(mask, temps);
      waitGrant(w);
      e = pickGrant(mask, mLast);
      checkOutput("rand_wait", 32'(w), 32'd0);
      checkOutput("rand_gnt", {28'd0, gnt}, 32'(1 << e));
      mLast = e;
      finishTxn(e, temps[e*8 +: 8], 1'b0);
      if ((n % 10) == 9) pulseAck(4'($urandom_range(0, 15)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
